// File: rtl/pio_int_pkg.sv
// Shared constants and per-source state encoding for the PIO Mode-2 interrupt scheduler.
package pio_int_pkg;

    localparam int NSRC_DEF = 2;

    localparam logic [7:0] OP_ED = 8'hED;
    localparam logic [7:0] OP_4D = 8'h4D;
    localparam logic [7:0] OP_CB = 8'hCB;

    // bit 0 = pend, bit 1 = serv
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PEND      = 2'b01,
        SERV      = 2'b10,
        SERV_PEND = 2'b11
    } src_state_t;

endpackage

// File: rtl/pio_int_slot.sv
// One interrupt source: pending/in-service bits plus its link in the internal enable chain.
//
// state     | meaning
// IDLE      | nothing pending, not in service
// PEND      | request latched, waiting for acknowledge
// SERV      | acknowledged, waiting for RETI
// SERV_PEND | in service with a new request latched behind it
module pio_int_slot (
    input  logic clk,
    input  logic rst_n,
    input  logic int_req,
    input  logic int_en,
    input  logic enabled_in,
    input  logic ack_sel,
    input  logic reti_sel,
    output logic req,
    output logic in_pend,
    output logic in_serv,
    output logic enabled_out,
    output logic pend_nxt,
    output logic blk_nxt
);
    import pio_int_pkg::*;

    src_state_t state_q, state_d;
    logic       pend_d, serv_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A request arriving in the acknowledge cycle survives the pend clear.
    always_comb begin
        pend_d  = (int_req & int_en) | (state_q[0] & int_en & ~ack_sel);
        serv_d  = ack_sel | (state_q[1] & ~reti_sel);
        state_d = src_state_t'({serv_d, pend_d});
    end

    assign in_pend     = state_q[0];
    assign in_serv     = state_q[1];
    assign req         = in_pend & ~in_serv & enabled_in;
    assign enabled_out = enabled_in & ~in_serv;
    assign pend_nxt    = pend_d;
    // Blocks this and lower sources in the cycle of a retire or acknowledge too.
    assign blk_nxt     = in_serv | serv_d;

endmodule

// File: rtl/pio_int_sched.sv
// Z80 Mode-2 interrupt scheduler: fixed-priority sources behind one daisy-chain slot,
// INTA vector supply and RETI (ED 4D) retirement.
module pio_int_sched
    import pio_int_pkg::*;
#(
    parameter int NSRC = NSRC_DEF
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic [7:0]        DI,
    input  logic              M1_n,
    input  logic              IORQ_n,
    input  logic              RD_n,
    input  logic              IEI,
    output logic              IEO,
    output logic              INT_n,
    input  logic [NSRC-1:0]   INT_REQ,
    input  logic [NSRC-1:0]   INT_EN,
    input  logic [8*NSRC-1:0] VECT,
    output logic [7:0]        DO,
    output logic              DO_EN,
    output logic [NSRC-1:0]   INT_ACK,
    output logic [NSRC-1:0]   INT_DONE
);

    logic [NSRC-1:0] req, in_pend, in_serv, pend_nxt, blk_nxt, ack_sel, reti_sel;
    logic [NSRC:0]   en_chain;
    logic            inta_act, inta_q, inta_det;
    logic            fetch_act, fetch_q, commit, reti;
    logic [7:0]      op_q, vect_sel, do_q;
    logic            ed_seen, last_cb, do_en_q, int_n_q;
    logic [NSRC-1:0] ack_q, done_q;
    logic            ack_hit, reti_hit, nxt_en, req_next_any;

    assign en_chain[0] = IEI;

    for (genvar g = 0; g < NSRC; g++) begin : g_slot
        pio_int_slot u_slot (
            .clk         (CLK),
            .rst_n       (RESET_n),
            .int_req     (INT_REQ[g]),
            .int_en      (INT_EN[g]),
            .enabled_in  (en_chain[g]),
            .ack_sel     (ack_sel[g]),
            .reti_sel    (reti_sel[g]),
            .req         (req[g]),
            .in_pend     (in_pend[g]),
            .in_serv     (in_serv[g]),
            .enabled_out (en_chain[g+1]),
            .pend_nxt    (pend_nxt[g]),
            .blk_nxt     (blk_nxt[g])
        );
    end

    assign inta_act  = ~M1_n & ~IORQ_n;
    assign inta_det  = inta_act & ~inta_q;
    assign fetch_act = ~M1_n & ~RD_n & IORQ_n;
    assign commit    = fetch_q & ~fetch_act;
    assign reti      = commit & (op_q == OP_4D) & ed_seen & IEI;

    always_comb begin
        ack_sel      = '0;
        reti_sel     = '0;
        vect_sel     = 8'h00;
        ack_hit      = 1'b0;
        reti_hit     = 1'b0;
        nxt_en       = IEI;
        req_next_any = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (req[i] && !ack_hit) begin
                ack_sel[i] = inta_det;
                vect_sel   = VECT[8*i +: 8];
                ack_hit    = 1'b1;
            end
            if (in_serv[i] && !reti_hit) begin
                reti_sel[i] = reti;
                reti_hit    = 1'b1;
            end
            // INT_n is registered, so it is derived from the state being loaded this edge.
            req_next_any = req_next_any | (pend_nxt[i] & ~blk_nxt[i] & nxt_en);
            nxt_en       = nxt_en & ~blk_nxt[i];
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            inta_q  <= 1'b0;
            fetch_q <= 1'b0;
            op_q    <= 8'h00;
            ed_seen <= 1'b0;
            last_cb <= 1'b0;
            do_q    <= 8'h00;
            do_en_q <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
            int_n_q <= 1'b1;
        end else begin
            inta_q  <= inta_act;
            fetch_q <= fetch_act;
            if (fetch_act) begin
                op_q <= DI;
            end
            if (commit) begin
                ed_seen <= (op_q == OP_ED) & ~last_cb;
                last_cb <= (op_q == OP_CB);
            end
            if (|ack_sel) begin
                do_q    <= vect_sel;
                do_en_q <= 1'b1;
            end else if (!inta_act) begin
                do_en_q <= 1'b0;
            end
            ack_q   <= ack_sel;
            done_q  <= reti_sel;
            int_n_q <= ~req_next_any;
        end
    end

    assign IEO      = en_chain[NSRC] & ~(|in_pend & ~ed_seen);
    assign INT_n    = int_n_q;
    assign DO       = do_q;
    assign DO_EN    = do_en_q;
    assign INT_ACK  = ack_q;
    assign INT_DONE = done_q;

endmodule

// File: tb/tb_pio_int_sched.sv
// Self-checking bench for pio_int_sched: table-driven single acknowledges plus
// hand-written priority, nesting, RETI-decode and reset sequences.
module tb_pio_int_sched;
    import pio_int_pkg::*;

    logic        CLK, RESET_n, M1_n, IORQ_n, RD_n, IEI, IEO, INT_n, DO_EN;
    logic [7:0]  DI, DO;
    logic [1:0]  INT_REQ, INT_EN, INT_ACK, INT_DONE;
    logic [15:0] VECT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] ack;
        logic [7:0] dout;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0] req;
        logic [1:0] en;
        logic [7:0] v0;
        logic [7:0] v1;
        logic [1:0] ack;
        logic [7:0] dout;
    } vec_t;
    vec_t tbl[6];

    pio_int_sched #(.NSRC(2)) dut (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .DI       (DI),
        .M1_n     (M1_n),
        .IORQ_n   (IORQ_n),
        .RD_n     (RD_n),
        .IEI      (IEI),
        .IEO      (IEO),
        .INT_n    (INT_n),
        .INT_REQ  (INT_REQ),
        .INT_EN   (INT_EN),
        .VECT     (VECT),
        .DO       (DO),
        .DO_EN    (DO_EN),
        .INT_ACK  (INT_ACK),
        .INT_DONE (INT_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_n = 1'b0;
        tick();
        tick();
        RESET_n = 1'b1;
        tick();
    endtask

    task automatic pulse_req(input logic [1:0] m, input logic exp_int_n);
        INT_REQ = m;
        tick();
        INT_REQ = 2'b00;
        check("int_n_after_req", 32'(INT_n), 32'(exp_int_n));
    endtask

    task automatic inta(input logic [1:0] ack, input logic [7:0] dv);
        exp_t e;
        e.ack  = ack;
        e.dout = dv;
        sb.push_back(e);
        M1_n   = 1'b0;
        IORQ_n = 1'b0;
        tick();
        e = sb.pop_front();
        check("do_en_inta", 32'(DO_EN), 32'(e.ack != 2'b00));
        check("int_ack", 32'(INT_ACK), 32'(e.ack));
        if (e.ack != 2'b00) check("do_vector", 32'(DO), 32'(e.dout));
        check("int_n_after_ack", 32'(INT_n), 32'd1);
        tick();
        check("int_ack_one_cycle", 32'(INT_ACK), 32'd0);
        check("do_en_hold", 32'(DO_EN), 32'(e.ack != 2'b00));
        M1_n   = 1'b1;
        IORQ_n = 1'b1;
        tick();
        check("do_en_fall", 32'(DO_EN), 32'd0);
    endtask

    task automatic fetch(input logic [7:0] op);
        M1_n = 1'b0;
        RD_n = 1'b0;
        DI   = op;
        tick();
        M1_n = 1'b1;
        RD_n = 1'b1;
        tick();
    endtask

    task automatic reti(input logic [1:0] done);
        fetch(OP_ED);
        fetch(OP_4D);
        check("int_done", 32'(INT_DONE), 32'(done));
        check("int_n_at_done", 32'(INT_n), 32'd1);
        tick();
        check("int_done_one_cycle", 32'(INT_DONE), 32'd0);
    endtask

    initial begin
        RESET_n = 1'b0;
        DI      = 8'h00;
        M1_n    = 1'b1;
        IORQ_n  = 1'b1;
        RD_n    = 1'b1;
        IEI     = 1'b1;
        INT_REQ = 2'b00;
        INT_EN  = 2'b11;
        VECT    = {8'h46, 8'h40};

        tbl[0] = '{req: 2'b10, en: 2'b11, v0: 8'h40, v1: 8'h46, ack: 2'b10, dout: 8'h46};
        tbl[1] = '{req: 2'b01, en: 2'b11, v0: 8'h40, v1: 8'h46, ack: 2'b01, dout: 8'h40};
        tbl[2] = '{req: 2'b11, en: 2'b11, v0: 8'hA0, v1: 8'hA2, ack: 2'b01, dout: 8'hA0};
        tbl[3] = '{req: 2'b10, en: 2'b01, v0: 8'h40, v1: 8'h46, ack: 2'b00, dout: 8'h00};
        tbl[4] = '{req: 2'b01, en: 2'b00, v0: 8'h40, v1: 8'h46, ack: 2'b00, dout: 8'h00};
        tbl[5] = '{req: 2'b10, en: 2'b10, v0: 8'h5C, v1: 8'hE7, ack: 2'b10, dout: 8'hE7};

        #12;
        check("rst_int_n", 32'(INT_n), 32'd1);
        check("rst_do_en", 32'(DO_EN), 32'd0);
        check("rst_do", 32'(DO), 32'd0);
        check("rst_int_ack", 32'(INT_ACK), 32'd0);
        check("rst_int_done", 32'(INT_DONE), 32'd0);
        check("rst_ieo", 32'(IEO), 32'(IEI));
        RESET_n = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) begin
            do_reset();
            INT_EN = tbl[k].en;
            VECT   = {tbl[k].v1, tbl[k].v0};
            pulse_req(tbl[k].req, ~|(tbl[k].req & tbl[k].en));
            inta(tbl[k].ack, tbl[k].dout);
            check("ieo_after_inta", 32'(IEO), 32'(tbl[k].ack == 2'b00));
        end

        // Fixed priority: source 0 first, source 1 only after source 0 retires.
        do_reset();
        INT_EN = 2'b11;
        VECT   = {8'h46, 8'h40};
        pulse_req(2'b11, 1'b0);
        inta(2'b01, 8'h40);
        reti(2'b01);
        check("int_n_src1_after_reti", 32'(INT_n), 32'd0);
        inta(2'b10, 8'h46);
        reti(2'b10);
        check("int_n_idle", 32'(INT_n), 32'd1);
        check("ieo_idle", 32'(IEO), 32'd1);
        IEI = 1'b0;
        #1;
        check("ieo_comb_low", 32'(IEO), 32'd0);
        IEI = 1'b1;
        #1;
        check("ieo_comb_high", 32'(IEO), 32'd1);

        // Nesting: source 0 interrupts source 1's service routine.
        pulse_req(2'b10, 1'b0);
        inta(2'b10, 8'h46);
        pulse_req(2'b01, 1'b0);
        inta(2'b01, 8'h40);
        reti(2'b01);
        reti(2'b10);

        // CB-prefixed ED and IEI=0 must not be taken as RETI.
        pulse_req(2'b01, 1'b0);
        inta(2'b01, 8'h40);
        fetch(OP_CB);
        fetch(OP_ED);
        fetch(OP_4D);
        check("cb_ed_4d_no_done", 32'(INT_DONE), 32'd0);
        check("ieo_in_serv", 32'(IEO), 32'd0);
        IEI = 1'b0;
        fetch(OP_ED);
        fetch(OP_4D);
        check("iei0_no_done", 32'(INT_DONE), 32'd0);
        IEI = 1'b1;
        tick();
        reti(2'b01);

        // Re-request latched while in service waits for RETI.
        pulse_req(2'b01, 1'b0);
        inta(2'b01, 8'h40);
        pulse_req(2'b01, 1'b1);
        tick();
        check("int_n_held_in_serv", 32'(INT_n), 32'd1);
        reti(2'b01);
        check("int_n_after_done", 32'(INT_n), 32'd0);
        inta(2'b01, 8'h40);
        reti(2'b01);

        // Reset in the middle of an acknowledge.
        pulse_req(2'b10, 1'b0);
        M1_n   = 1'b0;
        IORQ_n = 1'b0;
        tick();
        check("pre_rst_do_en", 32'(DO_EN), 32'd1);
        check("pre_rst_do", 32'(DO), 32'h46);
        RESET_n = 1'b0;
        #1;
        check("midrst_do_en", 32'(DO_EN), 32'd0);
        check("midrst_int_n", 32'(INT_n), 32'd1);
        check("midrst_do", 32'(DO), 32'd0);
        check("midrst_ieo", 32'(IEO), 32'(IEI));
        RESET_n = 1'b1;
        tick();
        check("post_rst_do_en", 32'(DO_EN), 32'd0);
        check("post_rst_ack", 32'(INT_ACK), 32'd0);
        M1_n   = 1'b1;
        IORQ_n = 1'b1;
        tick();
        M1_n   = 1'b0;
        IORQ_n = 1'b0;
        tick();
        check("later_inta_no_do_en", 32'(DO_EN), 32'd0);
        M1_n   = 1'b1;
        IORQ_n = 1'b1;
        tick();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_int_sched.md
# pio_int_sched

Synchronous Z80 Mode-2 interrupt scheduler for the Z8420 PIO core. It arbitrates NSRC internal interrupt sources (port A, port B, …) behind a single daisy-chain position, in fixed priority. It drives INT_n and IEO, supplies the vector during interrupt acknowledge, and retires the in-service source on RETI (ED 4D). It sits between the port control logic and the CPU bus interface, clocked by the CPU clock.

## Interface
- NSRC, 2: number of internal sources; index 0 has the highest priority.
- CLK  in  1  CPU clock; all bus inputs are sampled on its rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- DI  in  8  CPU data bus (opcode fetch byte).
- M1_n, IORQ_n, RD_n  in  1 each  Z80 bus strobes, active low.
- IEI  in  1  daisy-chain enable in.
- IEO  out  1  daisy-chain enable out.
- INT_n  out  1  interrupt request to CPU, active low.
- INT_REQ  in  NSRC  per-source request pulse, one CLK wide, from port logic.
- INT_EN  in  NSRC  per-source interrupt enable.
- VECT  in  8*NSRC  per-source vector byte; source i occupies bits [8i+7:8i].
- DO  out  8  vector byte.
- DO_EN  out  1  drive DO onto the bus.
- INT_ACK  out  NSRC  one-cycle pulse when source i is acknowledged.
- INT_DONE  out  NSRC  one-cycle pulse when source i is retired by RETI.

## Operation
- Each source holds two independent state bits:
  - pend: set by INT_REQ & INT_EN; cleared when INT_EN=0 or when the source is acknowledged.
  - serv: set on acknowledge; cleared on RETI.
- Effective states: IDLE (both bits 0), PEND, SERV, SERV+PEND (new request latched while the source is in service).
- Internal chain: source i is enabled iff IEI=1 and no source j<i has serv=1.
- Request condition: pend_i & ~serv_i & enabled_i.
- INT_n = 0 iff any source meets the request condition.
- IEO = IEI & ~any_serv & ~(any_pend & ~ed_seen). IEO is combinational from IEI and registered state only.
- Acknowledge (INTA):
  - INTA is detected on the first cycle in which M1_n=0 & IORQ_n=0 are sampled.
  - If IEI=1, the lowest-index source meeting the request condition moves from pend to serv.
  - That cycle: INT_ACK[i] pulses and DO is loaded with VECT[i].
  - If no source qualifies, INTA is ignored: no DO_EN, no state change.
- Opcode tracking:
  - A fetch is M1_n=0 & RD_n=0 & IORQ_n=1.
  - The opcode is DI as sampled in the last fetch-active cycle. It is committed on the first cycle with the fetch inactive.
  - ed_seen is set when the committed opcode is 8'hED and the previous committed opcode was not 8'hCB.
  - ed_seen is cleared by any other committed opcode.
- RETI: a committed 8'h4D with ed_seen=1 and IEI=1 clears serv on the lowest-index source with serv=1, and pulses INT_DONE[i]. If that source's pend=1, it re-requests on the next cycle.
- RETI with IEI=0 is ignored: a higher-priority device owns the RETI.
- Simultaneous events:
  - INT_REQ and acknowledge of the same source in one cycle: pend stays 1 and serv is set.
  - INT_EN falling in the INTA detect cycle: acknowledge wins for that cycle.
- Reset values: INT_n=1, IEO=IEI, DO=8'h00, DO_EN=0, INT_ACK=0, INT_DONE=0, all pend/serv/ed_seen cleared.
- Reset mid-acknowledge immediately drops DO_EN.

## Timing
- INT_REQ at cycle N: pend set at N+1, INT_n low at N+1 (INT_n is a registered output).
- INTA detect at cycle N:
  - DO valid and DO_EN=1 from N+1 while M1_n=0 & IORQ_n=0 remain sampled.
  - DO_EN falls the cycle after IORQ_n is sampled high.
  - INT_n rises at N+1.
- Opcode commit at cycle N: ed_seen updates at N+1. A RETI commit at N clears serv at N+1, with INT_DONE high during N+1.
- IEO is combinational: an IEI change propagates within the same cycle.
- No back-pressure and no handshake beyond the bus strobes; the CPU timing guarantees INTA lasts at least 2 CLK.

## Structure
- Package pio_int_pkg holds:
  - opcode constants OP_ED=8'hED, OP_4D=8'h4D, OP_CB=8'hCB;
  - a localparam for the default NSRC;
  - the source state encoding (IDLE, PEND, SERV, SERV_PEND) for debug visibility.
- Sub-module pio_int_slot, instantiated NSRC times:
  - holds pend/serv;
  - takes enabled_in, ack_sel, reti_sel;
  - produces req, in_serv and the chained enable out.
- The top level contains the bus strobe edge detection, opcode tracker, priority select, and the DO register.

## Test plan
- INT_REQ[1] pulse with IEI=1, then INTA → INT_n low 1 cycle after the request; DO=VECT[1] (e.g. 8'h46) with DO_EN=1; INT_ACK[1] pulses; INT_n returns high.
- INT_REQ[0] and INT_REQ[1] in the same cycle, then two INTA/RETI sequences → source 0 is acknowledged first (DO=VECT[0]=8'h40). Source 1 requests only after the RETI fetch sequence ED,4D retires source 0.
- Source 1 in SERV, then INT_REQ[0] → INT_n low and source 0 acknowledged (nesting). The first RETI retires source 0 only (INT_DONE=2'b01); the second retires source 1.
- Fetch sequence CB,ED,4D with source 0 in SERV → no INT_DONE and serv stays set. The sequence ED,4D with IEI=0 → also ignored.
- INT_REQ[0] pulse while source 0 is in SERV → no INT_n until RETI. INT_n falls 1 cycle after INT_DONE[0].
- RESET_n asserted during INTA with DO_EN=1 → DO_EN=0 and INT_n=1 immediately; DO=8'h00; IEO follows IEI; a later INTA produces no DO_EN.
